clkdiv_rate_ctrl: RTL
=====================

Name: clkdiv_rate_ctrl

Overview:
- Run/stop and rate-select controller for a single 50%-duty clock divider; the divider counter is embedded.
- Host selects one of four divisors through a valid/ready config handshake.
- Rate changes and stops take effect only at period boundaries, so the output never shows a runt pulse.
- Feeds slow enables/clocks (5 Hz class) to display, debounce and blink logic.

Parameters:
DIV_W, 28, counter width
DIV0, 28'd20000000, divisor for sel=0 (5 Hz from 100 MHz)
DIV1, 28'd10000000, divisor for sel=1 (10 Hz)
DIV2, 28'd50000000, divisor for sel=2 (2 Hz)
DIV3, 28'd100000000, divisor for sel=3 (1 Hz); all DIVn must be >=2 and <2^DIV_W

Ports:
clock_in  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = run divider, 0 = stop at end of current period
cfg_valid  in  1  new rate request
cfg_sel  in  2  requested divisor index
cfg_ready  out  1  high when a request can be accepted
clock_out  out  1  divided clock, registered
tick  out  1  one-cycle pulse on the first cycle of every period, registered
busy  out  1  high in RUN or PEND
active_sel  out  2  divisor index currently in use

Behaviour:
- Interface: one clock, clock_in. Reset is synchronous and active-high.
- Reset, any state, mid-period included: state=IDLE, count=0, clock_out=0, tick=0, busy=0, active_sel=0, pending cleared, cfg_ready=1.
- div = DIVn selected by active_sel. Period length = div cycles. clock_out is high for floor(div/2) cycles, then low. The high phase starts each period.
- States:
  - IDLE: count held at 0; clock_out=0; tick=0. If enable=1, go to RUN. On the next cycle count=0, clock_out=1 and tick=1 (latency 1 cycle from enable).
  - RUN: count increments each cycle. At count==div-1 (wrap), count goes to 0 and tick=1 on the following cycle. Registered outputs are computed from count_next: clock_out = (count_next < div/2); tick = (count_next==0).
  - PEND: same as RUN, with a rate change held in pending_sel.
- Transitions:
  - RUN to PEND on an accepted request.
  - PEND to RUN at wrap; active_sel takes pending_sel at that wrap, and the new period uses the new div.
  - RUN/PEND to IDLE at wrap if enable=0 sampled in the wrap cycle. clock_out=0 and tick=0 afterward.
- Handshake: accept = cfg_valid & cfg_ready.
  - cfg_ready = 1 in IDLE and RUN, 0 in PEND.
  - Accepted in IDLE: active_sel updates on the next cycle.
  - Accepted in RUN on a non-wrap cycle: enter PEND.
  - Accepted in RUN on the wrap cycle: applied at that same wrap; stay in RUN.
  - cfg_valid while cfg_ready=0: request is not taken; requester holds it.
- Stop with change pending: the change is applied at the stopping wrap, then IDLE.
- enable re-asserted before the wrap: no stop; the period continues seamlessly.
- busy = (state != IDLE).
- Count never exceeds div-1. Compare uses count >= div-1 as the wrap guard, so it stays safe after a shortening change.

Optional Feature:
CLKDIV_RATE_CTRL_STATUS_EN
- Defined: adds output period_cnt [15:0]. It increments on every tick, saturates at 16'hFFFF, and clears on reset and on every applied rate change.
- Undefined: no port, no counter logic.

Decomposition:
- Package clkdiv_pkg holds:
  - state encoding IDLE/RUN/PEND (2-bit)
  - DIV_W default
  - SEL_W=2
- One sub-module, clkdiv_core: counter, wrap detect, clock_out/tick registers. Its inputs are div and a run flag.
- FSM and handshake stay in clkdiv_rate_ctrl.

Test Plan:
- DIV0..3=4,6,10,20; reset, enable=1 -> cycle 1: tick=1, clock_out=1. clock_out pattern 1,1,0,0 repeating; tick every 4 cycles.
- Running sel=0, request sel=1 at count=1 -> cfg_ready=0 until wrap. Next period is 6 cycles (1,1,1,0,0,0) with no runt pulse; active_sel=1 from the wrap.
- Request sel=2 exactly on the wrap cycle -> accepted, cfg_ready stays 1. The next period is 10 cycles.
- enable=0 at count=1 of a 6-cycle period -> period completes (3 high, 3 low), then IDLE: clock_out=0, busy=0, no further ticks.
- Reset asserted at count=3 of a 10-cycle period with a change pending -> next cycle all outputs 0, active_sel=0, cfg_ready=1.
- With CLKDIV_RATE_CTRL_STATUS_EN: run 5 periods -> period_cnt=5. Apply a rate change -> period_cnt=0.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and defaults for the clkdiv_rate_ctrl slice.
//   state_t   : controller states IDLE / RUN / PEND (2-bit)
//   DIV_W_DEF : default divider counter width
//   SEL_W     : divisor select width
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEF = 28;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_core.sv
// clkdiv_core: embedded 50%-duty divider counter with wrap detect and
// registered clock/tick outputs.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_run        : divider runs in the coming cycle
//   i_div        : divisor in force for the coming cycle
//   o_wrap       : current cycle is the last cycle of the period
//   o_clk        : divided clock (high for floor(div/2) cycles per period)
//   o_tick       : one-cycle pulse on the first cycle of each period
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_wrap,
  output logic             o_clk,
  output logic             o_tick
);

  logic             r_run;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_count;
  logic             r_clk;
  logic             r_tick;
  logic [DIV_W-1:0] w_count_next;

  // >= keeps the wrap safe if the divisor in force ever shrinks below count
  always_comb begin
    o_wrap       = r_run && (r_count >= r_div - DIV_W'(1));
    w_count_next = '0;
    if (i_run && r_run && !o_wrap) begin
      w_count_next = r_count + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run   <= 1'b0;
      r_div   <= '0;
      r_count <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_run   <= i_run;
      r_div   <= i_div;
      r_count <= w_count_next;
      r_clk   <= i_run && (w_count_next < (i_div >> 1));
      r_tick  <= i_run && (w_count_next == '0);
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clkdiv_rate_ctrl.sv
// clkdiv_rate_ctrl: run/stop and rate-select controller for a 50%-duty
// clock divider; rate changes and stops land only on period boundaries.
//   clock_in, reset       : clock, synchronous active-high reset
//   enable                : 1 = run, 0 = stop at end of current period
//   cfg_valid/sel/ready   : divisor-select request handshake
//   clock_out, tick       : divided clock, first-cycle-of-period pulse
//   busy, active_sel      : not idle, divisor index in use
//   period_cnt            : saturating tick count since last rate change,
//                           present only with CLKDIV_RATE_CTRL_STATUS_EN
module clkdiv_rate_ctrl
  import clkdiv_pkg::*;
#(
  parameter int unsigned      DIV_W = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV0  = 28'd20000000,
  parameter logic [DIV_W-1:0] DIV1  = 28'd10000000,
  parameter logic [DIV_W-1:0] DIV2  = 28'd50000000,
  parameter logic [DIV_W-1:0] DIV3  = 28'd100000000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic             clock_out,
  output logic             tick,
  output logic             busy,
  output logic [SEL_W-1:0] active_sel
`ifdef CLKDIV_RATE_CTRL_STATUS_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_active_sel;
  logic [SEL_W-1:0] r_pend_sel;
  logic [SEL_W-1:0] w_sel_next;
  logic [SEL_W-1:0] w_pend_next;
  logic [DIV_W-1:0] w_div_next;
  logic             w_accept;
  logic             w_wrap;
  logic             w_tick;

  always_comb begin
    cfg_ready = (r_state != PEND);
    busy      = (r_state != IDLE);
    w_accept  = cfg_valid && cfg_ready;
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_active_sel;
    w_pend_next  = r_pend_sel;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_sel_next = cfg_sel;
        if (enable)   w_state_next = RUN;
      end
      RUN: begin
        if (w_wrap) begin
          if (w_accept) w_sel_next = cfg_sel;
          w_state_next = enable ? RUN : IDLE;
        end else if (w_accept) begin
          w_pend_next  = cfg_sel;
          w_state_next = PEND;
        end
      end
      PEND: begin
        if (w_wrap) begin
          w_sel_next   = r_pend_sel;
          w_state_next = enable ? RUN : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // the divisor follows the next selection so a switched period starts on the new rate
  always_comb begin
    unique case (w_sel_next)
      2'd0:    w_div_next = DIV0;
      2'd1:    w_div_next = DIV1;
      2'd2:    w_div_next = DIV2;
      default: w_div_next = DIV3;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state      <= IDLE;
      r_active_sel <= '0;
      r_pend_sel   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_active_sel <= w_sel_next;
      r_pend_sel   <= w_pend_next;
    end
  end

  clkdiv_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .i_clk  (clock_in),
    .i_rst  (reset),
    .i_run  (w_state_next != IDLE),
    .i_div  (w_div_next),
    .o_wrap (w_wrap),
    .o_clk  (clock_out),
    .o_tick (w_tick)
  );

  assign tick       = w_tick;
  assign active_sel = r_active_sel;

`ifdef CLKDIV_RATE_CTRL_STATUS_EN
  logic        w_apply;
  logic [15:0] r_period_cnt;

  always_comb begin
    w_apply = (w_accept && ((r_state == IDLE) || w_wrap)) ||
              ((r_state == PEND) && w_wrap);
  end

  always_ff @(posedge clock_in) begin
    if (reset || w_apply) begin
      r_period_cnt <= '0;
    end else if (w_tick && (r_period_cnt != '1)) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule
